// File: rtl/operand_hazard_gate.sv
// Decode-side consumer of the register-invalid scoreboard: stalls on operand hazards,
// picks regfile or writeback bypass per operand and issues into ID/EX with backpressure.
module operand_hazard_gate #(
    parameter int STALL_THRESH = 2,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_decode,
    input  logic             id_valid,
    input  logic             id_use_ra,
    input  logic             id_use_rb,
    input  logic [2:0]       id_ra_adr,
    input  logic [2:0]       id_rb_adr,
    input  logic [7:0][2:0]  register_invalid,
    input  logic             ex_ready,
    output logic             stall_decode,
    output logic             ex_valid,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic             hazard_timeout
);

    localparam logic [2:0] THRESH     = 3'(STALL_THRESH);
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] run_cnt;

    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
    logic       hz_a;
    logic       hz_b;
    logic       live;
    logic       hazard;
    logic       backpressure;
    logic       issue;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    assign cnt_a = register_invalid[id_ra_adr];
    assign cnt_b = register_invalid[id_rb_adr];

    // A count of exactly one means the producer is in writeback and can be bypassed.
    assign hz_a = id_use_ra && (cnt_a >= THRESH);
    assign hz_b = id_use_rb && (cnt_b >= THRESH);

    assign live         = id_valid && !flush_decode;
    assign hazard       = live && (hz_a || hz_b);
    assign backpressure = ex_valid && !ex_ready;
    assign stall_decode = live && (hazard || backpressure);
    assign issue        = live && !stall_decode;

    assign fwd_a_next = (id_use_ra && cnt_a == 3'd1) ? 2'b01 : 2'b00;
    assign fwd_b_next = (id_use_rb && cnt_b == 3'd1) ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_fwd_a <= 2'b00;
            ex_fwd_b <= 2'b00;
        end else if (!backpressure) begin
            if (issue) begin
                ex_valid <= 1'b1;
                ex_fwd_a <= fwd_a_next;
                ex_fwd_b <= fwd_b_next;
            end else begin
                ex_valid <= 1'b0;
                ex_fwd_a <= 2'b00;
                ex_fwd_b <= 2'b00;
            end
        end
    end

    // Only true data-hazard cycles feed the perf counter and the stuck-stall watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count    <= '0;
            run_cnt        <= 8'd0;
            hazard_timeout <= 1'b0;
        end else begin
            if (hazard && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            if (hazard) begin
                if (run_cnt != 8'hFF) begin
                    run_cnt <= run_cnt + 8'd1;
                end
                if (run_cnt == TIMEOUT_M1) begin
                    hazard_timeout <= 1'b1;
                end
            end else begin
                run_cnt <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else if (flush_decode) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (hazard)            state <= STALL;
                    else if (stall_decode) state <= HOLD;
                    else                   state <= RUN;
                end
                STALL: begin
                    if (issue || !id_valid) state <= RUN;
                    else if (hazard)        state <= STALL;
                    else                    state <= HOLD;
                end
                HOLD: begin
                    if (hazard)             state <= STALL;
                    else if (!stall_decode) state <= RUN;
                    else                    state <= HOLD;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_hazard_gate.sv
// Directed bench for operand_hazard_gate; built with CNT_W=4 so saturation is reachable.
module tb_operand_hazard_gate;

    logic            clk;
    logic            reset;
    logic            flush_decode;
    logic            id_valid;
    logic            id_use_ra;
    logic            id_use_rb;
    logic [2:0]      id_ra_adr;
    logic [2:0]      id_rb_adr;
    logic [7:0][2:0] register_invalid;
    logic            ex_ready;
    logic            stall_decode;
    logic            ex_valid;
    logic [1:0]      ex_fwd_a;
    logic [1:0]      ex_fwd_b;
    logic [3:0]      stall_count;
    logic            hazard_timeout;

    int vec_count   = 0;
    int miscompares = 0;

    operand_hazard_gate #(.STALL_THRESH(2), .CNT_W(4), .TIMEOUT(15)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_decode     (flush_decode),
        .id_valid         (id_valid),
        .id_use_ra        (id_use_ra),
        .id_use_rb        (id_use_rb),
        .id_ra_adr        (id_ra_adr),
        .id_rb_adr        (id_rb_adr),
        .register_invalid (register_invalid),
        .ex_ready         (ex_ready),
        .stall_decode     (stall_decode),
        .ex_valid         (ex_valid),
        .ex_fwd_a         (ex_fwd_a),
        .ex_fwd_b         (ex_fwd_b),
        .stall_count      (stall_count),
        .hazard_timeout   (hazard_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic ura, input logic urb,
                                 input logic [2:0] ra, input logic [2:0] rb,
                                 input logic rdy, input logic fl);
        id_valid     = v;
        id_use_ra    = ura;
        id_use_rb    = urb;
        id_ra_adr    = ra;
        id_rb_adr    = rb;
        ex_ready     = rdy;
        flush_decode = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEx(input string tag, input logic v, input logic [1:0] fa, input logic [1:0] fb);
        checkOutput({tag, ".ex_valid"}, 32'(ex_valid), 32'(v));
        checkOutput({tag, ".ex_fwd_a"}, 32'(ex_fwd_a), 32'(fa));
        checkOutput({tag, ".ex_fwd_b"}, 32'(ex_fwd_b), 32'(fb));
    endtask

    task automatic checkStall(input string tag, input logic exp);
        #1;
        checkOutput({tag, ".stall_decode"}, 32'(stall_decode), 32'(exp));
    endtask

    task automatic checkReset(input string tag);
        checkEx(tag, 1'b0, 2'b00, 2'b00);
        checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'd0);
        checkOutput({tag, ".hazard_timeout"}, 32'(hazard_timeout), 32'd0);
        checkOutput({tag, ".state"}, 32'(dut.state), 32'd0);
    endtask

    initial begin
        int exp_sc;
        reset            = 1'b1;
        register_invalid = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        checkReset("reset");
        reset = 1'b0;

        // Clean issue, one-cycle latency into ID/EX.
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 3'd5, 1'b1, 1'b0);
        checkStall("t1", 1'b0);
        nextCycle();
        checkEx("t1", 1'b1, 2'b00, 2'b00);
        checkOutput("t1.state", 32'(dut.state), 32'd0);

        // Counter 2 stalls, 1 bypasses from writeback, 0 reads the regfile.
        register_invalid[3] = 3'd2;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 3'd5, 1'b1, 1'b0);
        checkStall("t2.cnt2", 1'b1);
        nextCycle();
        checkOutput("t2.bubble", 32'(ex_valid), 32'd0);
        checkOutput("t2.state_stall", 32'(dut.state), 32'd1);
        checkOutput("t2.stall_count", 32'(stall_count), 32'd1);
        register_invalid[3] = 3'd1;
        checkStall("t2.cnt1", 1'b0);
        nextCycle();
        checkEx("t2.bypass", 1'b1, 2'b01, 2'b00);
        checkOutput("t2.state_run", 32'(dut.state), 32'd0);
        checkOutput("t2.stall_count_hold", 32'(stall_count), 32'd1);
        register_invalid[3] = 3'd0;
        nextCycle();
        checkEx("t2.regfile", 1'b1, 2'b00, 2'b00);

        // Unused operand never hazards; same register on both operands.
        register_invalid[4] = 3'd3;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 3'd4, 1'b1, 1'b0);
        checkStall("t3.unused", 1'b0);
        nextCycle();
        checkEx("t3.unused", 1'b1, 2'b00, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 3'd4, 1'b1, 1'b0);
        checkStall("t3.used", 1'b1);
        nextCycle();
        checkOutput("t3.bubble", 32'(ex_valid), 32'd0);
        checkOutput("t3.state_stall", 32'(dut.state), 32'd1);
        checkOutput("t3.stall_count", 32'(stall_count), 32'd2);
        register_invalid[4] = 3'd1;
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 1'b1, 1'b0);
        checkStall("t3.same", 1'b0);
        nextCycle();
        checkEx("t3.same", 1'b1, 2'b01, 2'b01);
        checkOutput("t3.state_run", 32'(dut.state), 32'd0);
        register_invalid[4] = 3'd0;

        // Backpressure holds ID/EX and does not count as a hazard stall.
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkStall("t4.bp", 1'b1);
            nextCycle();
            checkEx("t4.hold", 1'b1, 2'b01, 2'b01);
            checkOutput("t4.state_hold", 32'(dut.state), 32'd2);
            checkOutput("t4.stall_count", 32'(stall_count), 32'd2);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1);
        checkStall("t4.flush_bp", 1'b0);
        nextCycle();
        checkEx("t4.flush_bp", 1'b1, 2'b01, 2'b01);
        checkOutput("t4.flush_state", 32'(dut.state), 32'd0);
        register_invalid[1] = 3'd2;
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0);
        checkStall("t4.both", 1'b1);
        nextCycle();
        checkEx("t4.both", 1'b1, 2'b01, 2'b01);
        checkOutput("t4.both_state", 32'(dut.state), 32'd1);
        checkOutput("t4.both_count", 32'(stall_count), 32'd3);
        register_invalid[1] = 3'd0;
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 1'b0);
        checkStall("t4.release", 1'b0);
        nextCycle();
        checkEx("t4.release", 1'b1, 2'b00, 2'b00);
        checkOutput("t4.release_state", 32'(dut.state), 32'd0);

        // Long hazard: counter saturates at 15, watchdog fires on the 15th cycle.
        register_invalid[1] = 3'd2;
        for (int i = 1; i <= 15; i++) begin
            nextCycle();
            exp_sc = (3 + i > 15) ? 15 : 3 + i;
            checkOutput($sformatf("t5.stall_count[%0d]", i), 32'(stall_count), 32'(exp_sc));
            checkOutput($sformatf("t5.timeout[%0d]", i), 32'(hazard_timeout), (i >= 15) ? 32'd1 : 32'd0);
        end
        checkOutput("t5.state_stall", 32'(dut.state), 32'd1);
        checkOutput("t5.bubble", 32'(ex_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 1'b1);
        checkStall("t5.flush", 1'b0);
        nextCycle();
        checkOutput("t5.flush_valid", 32'(ex_valid), 32'd0);
        checkOutput("t5.flush_state", 32'(dut.state), 32'd0);
        checkOutput("t5.flush_count", 32'(stall_count), 32'd15);
        register_invalid[1] = 3'd0;
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 1'b0);
        nextCycle();
        checkOutput("t5.reissue", 32'(ex_valid), 32'd1);
        checkOutput("t5.timeout_sticky", 32'(hazard_timeout), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 1'b1);
        nextCycle();
        checkOutput("t5.flush_kill", 32'(ex_valid), 32'd0);

        // Reset in the middle of a stall, then count up again from zero.
        register_invalid[1] = 3'd2;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0);
        nextCycle();
        reset = 1'b1;
        nextCycle();
        checkReset("t6.reset");
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            nextCycle();
            exp_sc = (i > 15) ? 15 : i;
            checkOutput($sformatf("t6.stall_count[%0d]", i), 32'(stall_count), 32'(exp_sc));
            checkOutput($sformatf("t6.timeout[%0d]", i), 32'(hazard_timeout), (i >= 15) ? 32'd1 : 32'd0);
        end
        checkOutput("t6.state", 32'(dut.state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
